// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-fetch front end:
//   - fetch_state_e : two-state fetch FSM encoding (FETCH / DELIVER)
//   - DEF_RESET_PC  : default PC loaded on reset
//   - DEF_PC_INC    : default sequential PC increment in bytes
//   - align_word()  : clears the byte-offset bits of an address
//   - is_misaligned(): reports a non-word-aligned address
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DELIVER = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_INC   = 32'd4;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational redirect arbiter. Picks one redirect target with priority
// jump_reg > jump > branch_taken and word-aligns it.
// Ports:
//   i_branch_taken / i_branch_target : conditional branch request and target
//   i_jump / i_jump_target           : direct jump request and target
//   i_jump_reg / i_rs                : register jump request and target
//   o_redirect                       : any redirect requested this cycle
//   o_target                         : selected target with bits[1:0] cleared
//   o_misaligned                     : selected target had bits[1:0] != 0
// -----------------------------------------------------------------------------
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_jump_reg,
    input  logic [31:0] i_rs,
    output logic        o_redirect,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    logic [31:0] w_raw_target;

    // Priority select of the raw redirect target; lower-priority requests are ignored.
    always_comb begin
        w_raw_target = 32'h0000_0000;
        if (i_jump_reg) begin
            w_raw_target = i_rs;
        end else if (i_jump) begin
            w_raw_target = i_jump_target;
        end else if (i_branch_taken) begin
            w_raw_target = i_branch_target;
        end else begin
            w_raw_target = 32'h0000_0000;
        end
    end

    assign o_redirect   = i_jump_reg | i_jump | i_branch_taken;
    assign o_target     = align_word(w_raw_target);
    assign o_misaligned = o_redirect & is_misaligned(w_raw_target);

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Two-state instruction fetch sequencer. FETCH issues a request at the PC and
// waits for an ack; DELIVER holds the fetched word until the consumer takes it.
// Redirects (jr/jump/branch) override sequential flow; a redirect that arrives
// while a request is outstanding is parked in a pending register so the
// request address stays stable, and the in-flight data is discarded.
// Ports:
//   Clk, reset (async active-low)
//   stall                         : consumer not ready
//   branch_taken/branch_target, jump/jump_target, jump_reg/rs : redirects
//   imem_req/imem_addr            : instruction memory request
//   imem_ack/imem_rdata           : memory response (data valid with ack)
//   instr_valid/instr/instr_pc    : delivered instruction
//   align_fault                   : sticky misaligned-redirect flag
//   instr_count                   : number of instructions consumed
// -----------------------------------------------------------------------------
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] rs,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        align_fault,
    output logic [31:0] instr_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic        r_req;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_fault;
    logic [31:0] r_count;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_req_next;
    logic        w_valid_next;
    logic [31:0] w_pc_next;
    logic        w_pend_valid_next;
    logic [31:0] w_pend_pc_next;
    logic        w_latch;
    logic        w_consume;
    logic        w_ack_live;

    next_pc_sel u_next_pc_sel (
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_jump_reg      (jump_reg),
        .i_rs            (rs),
        .o_redirect      (w_redirect),
        .o_target        (w_target),
        .o_misaligned    (w_misaligned)
    );

    // An ack only counts while a request is actually on the bus; this keeps a
    // stale ack arriving right after reset from being consumed.
    assign w_ack_live = (r_state == ST_FETCH) & r_req & imem_ack;

    // FSM state register.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_ack_live && !w_redirect && !r_pend_valid) begin
                    w_state_next = ST_DELIVER;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_DELIVER: begin
                if (w_redirect || !stall) begin
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_DELIVER;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // FSM outputs for the next cycle; registered below so they are glitch-free.
    always_comb begin
        w_req_next   = (w_state_next == ST_FETCH);
        w_valid_next = (w_state_next == ST_DELIVER);
    end

    // Datapath next values: PC, pending redirect, latch and consume strobes.
    always_comb begin
        w_pc_next         = r_pc;
        w_pend_valid_next = r_pend_valid;
        w_pend_pc_next    = r_pend_pc;
        w_latch           = 1'b0;
        w_consume         = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (!r_req) begin
                    // No request outstanding yet, so a redirect can move the PC directly.
                    if (w_redirect) begin
                        w_pc_next = w_target;
                    end else begin
                        w_pc_next = r_pc;
                    end
                end else if (imem_ack) begin
                    if (w_redirect) begin
                        w_pc_next         = w_target;
                        w_pend_valid_next = 1'b0;
                    end else if (r_pend_valid) begin
                        w_pc_next         = r_pend_pc;
                        w_pend_valid_next = 1'b0;
                    end else begin
                        w_latch   = 1'b1;
                        w_pc_next = r_pc + PC_INC;
                    end
                end else begin
                    // Request in flight: park the redirect, keep imem_addr stable.
                    if (w_redirect) begin
                        w_pend_valid_next = 1'b1;
                        w_pend_pc_next    = w_target;
                    end else begin
                        w_pend_valid_next = r_pend_valid;
                    end
                end
            end
            ST_DELIVER: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                end else if (!stall) begin
                    w_consume = 1'b1;
                end else begin
                    w_pc_next = r_pc;
                end
            end
            default: begin
                w_pc_next = r_pc;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_req        <= 1'b0;
            r_valid      <= 1'b0;
            r_pc         <= RESET_PC;
            r_instr      <= 32'h0000_0000;
            r_instr_pc   <= 32'h0000_0000;
            r_fault      <= 1'b0;
            r_count      <= 32'h0000_0000;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'h0000_0000;
        end else begin
            r_req        <= w_req_next;
            r_valid      <= w_valid_next;
            r_pc         <= w_pc_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_pc    <= w_pend_pc_next;
            r_fault      <= r_fault | w_misaligned;
            if (w_latch) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
            if (w_consume) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign align_fault = r_fault;
    assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed scenarios followed by a randomized run, checked against a
// transaction-level reference model of the fetch sequencer.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        Clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jump_reg;
    logic [31:0] rs;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        align_fault;
    logic [31:0] instr_count;

    int checks;
    int errors;

    // Reference model state: "started" = a request has been issued since reset,
    // "busy_deliver" = an instruction is being offered to the consumer.
    logic        m_started;
    logic        m_deliv;
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_count;
    logic        m_fault;

    fetch_sequencer dut (
        .Clk           (Clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .rs            (rs),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .align_fault   (align_fault),
        .instr_count   (instr_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_started = 1'b0;
        m_deliv   = 1'b0;
        m_pc      = 32'h0;
        m_pend    = 1'b0;
        m_pend_pc = 32'h0;
        m_instr   = 32'h0;
        m_ipc     = 32'h0;
        m_count   = 32'h0;
        m_fault   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic        red;
        logic [31:0] tgt;
        red = jump_reg | jump | branch_taken;
        tgt = jump_reg ? rs : (jump ? jump_target : branch_target);
        if (red && (tgt % 4 != 0)) m_fault = 1'b1;
        tgt = tgt - (tgt % 4);
        if (!m_started) begin
            if (red) m_pc = tgt;
            m_started = 1'b1;
        end else if (!m_deliv) begin
            if (imem_ack) begin
                if (red) begin
                    m_pc = tgt; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_pc = m_pend_pc; m_pend = 1'b0;
                end else begin
                    m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_deliv = 1'b1;
                end
            end else if (red) begin
                m_pend = 1'b1; m_pend_pc = tgt;
            end
        end else begin
            if (red) begin
                m_pc = tgt; m_deliv = 1'b0;
            end else if (!stall) begin
                m_count = m_count + 32'd1; m_deliv = 1'b0;
            end
        end
    endtask

    // Apply one cycle of inputs at the negedge, step the model, and return at the next negedge.
    task automatic drive_cycle(input logic s, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt, input logic jr,
                               input logic [31:0] r, input logic a, input logic [31:0] d);
        stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
        jump_reg = jr; rs = r; imem_ack = a; imem_rdata = d;
        model_step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if ({imem_req, instr_valid, align_fault} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got req/valid/fault=%b%b%b expected 000", imem_req, instr_valid, align_fault);
        end
        checks++;
        if ({imem_addr, instr, instr_pc, instr_count} !== 128'h0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h instr=%h pc=%h cnt=%h expected all 0",
                     imem_addr, instr, instr_pc, instr_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_req: got %b expected 0 before first edge", imem_req);
        end
    endtask

    task automatic test_fetch();
        @(negedge Clk);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL fetch_first_req: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: got addr=%h valid=%b expected 00000000 0", imem_addr, instr_valid);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2002_0005);
        checks++;
        if ({instr_valid, imem_req, instr, instr_pc, imem_addr} !== {1'b1, 1'b0, 32'h2002_0005, 32'h0, 32'h4}) begin
            errors++;
            $display("FAIL fetch_deliver: got valid=%b req=%b instr=%h pc=%h addr=%h expected 1 0 20020005 00000000 00000004",
                     instr_valid, imem_req, instr, instr_pc, imem_addr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if ({instr_valid, instr, instr_pc, imem_addr, instr_count} !==
                {1'b1, 32'h2002_0005, 32'h0, 32'h4, 32'h0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h addr=%h cnt=%0d expected 1 20020005 0 4 0",
                         i, instr_valid, instr, instr_pc, imem_addr, instr_count);
            end
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({instr_count, instr_valid, imem_req} !== {32'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: got cnt=%0d valid=%b req=%b expected 1 0 1", instr_count, instr_valid, imem_req);
        end
    endtask

    task automatic test_priority();
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D);
        drive_cycle(1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({imem_addr, instr_valid, imem_req, instr_count} !== {32'h40, 1'b0, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL jump_over_branch: got addr=%h valid=%b req=%b cnt=%0d expected 00000040 0 1 1",
                     imem_addr, instr_valid, imem_req, instr_count);
        end
    endtask

    task automatic test_pending();
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL pending_addr_stable1: got %h expected 00000040", imem_addr);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL pending_addr_stable2: got %h expected 00000040", imem_addr);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checks++;
        if ({imem_addr, instr_valid, imem_req, instr} !== {32'h100, 1'b0, 1'b1, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL pending_discard: got addr=%h valid=%b req=%b instr=%h expected 00000100 0 1 0badf00d",
                     imem_addr, instr_valid, imem_req, instr);
        end
    endtask

    task automatic test_align_wrap();
        drive_cycle(1'b0, 1'b1, 32'h46, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
        checks++;
        if ({imem_addr, align_fault, instr_valid} !== {32'h44, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL align_redirect: got addr=%h fault=%b valid=%b expected 00000044 1 0",
                     imem_addr, align_fault, instr_valid);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0005);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({align_fault, instr_pc, instr_count} !== {1'b1, 32'h44, 32'd2}) begin
            errors++;
            $display("FAIL align_sticky: got fault=%b pc=%h cnt=%0d expected 1 00000044 2",
                     align_fault, instr_pc, instr_count);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        checks++;
        if ({instr_pc, imem_addr, instr} !== {32'hFFFF_FFFC, 32'h0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%h addr=%h instr=%h expected fffffffc 00000000 12345678",
                     instr_pc, imem_addr, instr);
        end
    endtask

    task automatic test_random();
        logic [31:0] t0, t1, t2;
        int sel;
        for (int n = 0; n < 1500; n++) begin
            t0 = $urandom; t1 = $urandom; t2 = $urandom;
            if ($urandom_range(0, 7) != 0) t0[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) t1[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) t2[1:0] = 2'b00;
            sel = $urandom_range(0, 11);
            drive_cycle($urandom_range(0, 2) == 0,
                        (sel == 2 || sel == 3 || sel == 4), t0,
                        (sel == 1 || sel == 3), t1,
                        (sel == 0 || sel == 4), t2,
                        $urandom_range(0, 9) < 4, $urandom);
            checks++;
            if ({imem_req, instr_valid, align_fault, imem_addr, instr, instr_pc, instr_count} !==
                {m_started & ~m_deliv, m_deliv, m_fault, m_pc, m_instr, m_ipc, m_count}) begin
                errors++;
                $display("FAIL random[%0d]: got req=%b val=%b flt=%b addr=%h ins=%h pc=%h cnt=%h expected %b %b %b %h %h %h %h",
                         n, imem_req, instr_valid, align_fault, imem_addr, instr, instr_pc, instr_count,
                         m_started & ~m_deliv, m_deliv, m_fault, m_pc, m_instr, m_ipc, m_count);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_req: got %b expected 1", imem_req);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_0000;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, align_fault, imem_addr, instr_count} !== {3'b000, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got req=%b valid=%b fault=%b addr=%h cnt=%h expected 0 0 0 0 0",
                     imem_req, instr_valid, align_fault, imem_addr, instr_count);
        end
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0000);
        checks++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL late_ack_ignored: got req=%b valid=%b addr=%h expected 1 0 00000000",
                     imem_req, instr_valid, imem_addr);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0000);
        checks++;
        if ({instr_valid, instr, instr_pc, imem_addr, align_fault} !== {1'b1, 32'hCAFE_0000, 32'h0, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_fetch: got valid=%b instr=%h pc=%h addr=%h fault=%b expected 1 cafe0000 0 4 0",
                     instr_valid, instr, instr_pc, imem_addr, align_fault);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        jump_reg = 1'b0; rs = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_priority();
        test_pending();
        test_align_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
